// File: rtl/chess_clock_pkg.sv
// Shared field widths, time constants and FSM state encoding for the chess clock.
package chess_clock_pkg;

    localparam int MIN_W  = 3;
    localparam int TENS_W = 3;
    localparam int ONES_W = 4;
    localparam int TIME_W = MIN_W + TENS_W + ONES_W;

    localparam logic [TIME_W-1:0] MAX_TIME  = {3'd5, 3'd5, 4'd9};
    localparam logic [TIME_W-1:0] ZERO_TIME = {3'd0, 3'd0, 4'd0};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN_W   = 3'd1,
        ST_RUN_B   = 3'd2,
        ST_PAUSE_W = 3'd3,
        ST_PAUSE_B = 3'd4,
        ST_FLAG    = 3'd5
    } state_t;

    function automatic logic [TIME_W-1:0] pack_time(input logic [MIN_W-1:0] m,
                                                    input logic [TENS_W-1:0] t,
                                                    input logic [ONES_W-1:0] o);
        return {m, t, o};
    endfunction

endpackage

// File: rtl/bcd_time_step.sv
// Combinational one-second BCD decrement (floored at 0:00) and, with INCREMENT_EN,
// a saturating per-move BCD increment applied after the decrement.
module bcd_time_step
    import chess_clock_pkg::*;
(
    input  logic [TIME_W-1:0] word,
    input  logic              dec_en,
    input  logic              inc_en,
    input  logic [3:0]        inc_sec,
    output logic [TIME_W-1:0] next_word,
    output logic              is_zero
);

    logic [MIN_W-1:0]  min_s;
    logic [TENS_W-1:0] tens_s;
    logic [ONES_W-1:0] ones_s;
    logic [TIME_W-1:0] dec_word_s;

    assign min_s  = word[9:7];
    assign tens_s = word[6:4];
    assign ones_s = word[3:0];

    // One-second decrement with BCD borrow, never going below 0:00
    always_comb begin
        dec_word_s = word;
        if (!dec_en) begin
            dec_word_s = word;
        end else if (word == ZERO_TIME) begin
            dec_word_s = ZERO_TIME;
        end else if (ones_s != 4'd0) begin
            dec_word_s = pack_time(min_s, tens_s, ones_s - 4'd1);
        end else if (tens_s != 3'd0) begin
            dec_word_s = pack_time(min_s, tens_s - 3'd1, 4'd9);
        end else begin
            dec_word_s = pack_time(min_s - 3'd1, 3'd5, 4'd9);
        end
    end

    assign is_zero = (dec_word_s == ZERO_TIME);

`ifdef INCREMENT_EN
    logic [4:0] ones_raw_s;
    logic [4:0] ones_fix_s;
    logic       ones_carry_s;
    logic [3:0] tens_raw_s;
    logic [3:0] tens_fix_s;
    logic       tens_carry_s;
    logic [3:0] min_raw_s;
    logic       unused_carry_bits_s;

    assign ones_raw_s   = {1'b0, dec_word_s[3:0]} + {1'b0, inc_sec};
    assign ones_carry_s = (ones_raw_s > 5'd9);
    assign ones_fix_s   = ones_carry_s ? (ones_raw_s - 5'd10) : ones_raw_s;
    assign tens_raw_s   = {1'b0, dec_word_s[6:4]} + {3'b000, ones_carry_s};
    assign tens_carry_s = (tens_raw_s > 4'd5);
    assign tens_fix_s   = tens_carry_s ? (tens_raw_s - 4'd6) : tens_raw_s;
    assign min_raw_s    = {1'b0, dec_word_s[9:7]} + {3'b000, tens_carry_s};
    assign unused_carry_bits_s = ^{ones_fix_s[4], tens_fix_s[3]};

    // Increment is skipped when the same-cycle decrement has just flagged the mover
    always_comb begin
        next_word = dec_word_s;
        if (inc_en && !(dec_en && is_zero)) begin
            if (min_raw_s > 4'd5) begin
                next_word = MAX_TIME;
            end else begin
                next_word = pack_time(min_raw_s[2:0], tens_fix_s[2:0], ones_fix_s[3:0]);
            end
        end else begin
            next_word = dec_word_s;
        end
    end
`else
    logic unused_inc_s;

    assign unused_inc_s = ^{inc_en, inc_sec};
    assign next_word    = dec_word_s;
`endif

endmodule

// File: rtl/chess_clock_countdown.sv
// Two-player chess clock: turn FSM, one-second prescaler and per-player BCD countdown.
// Optional macro INCREMENT_EN adds INC_SEC seconds to the mover's time on each turn switch.
module chess_clock_countdown
    import chess_clock_pkg::*;
#(
    parameter int TICK_CYCLES = 100000000,
    parameter int START_MIN   = 5,
    parameter int START_TENS  = 0,
    parameter int START_ONES  = 0,
    parameter int INC_SEC     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              move_w,
    input  logic              move_b,
    input  logic              pause,
    output logic [TIME_W-1:0] countdown_w,
    output logic [TIME_W-1:0] countdown_b,
    output logic              active_w,
    output logic              active_b,
    output logic              flag_w,
    output logic              flag_b
);

    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_CYCLES - 1);
    localparam logic [TIME_W-1:0] START_TIME = {3'(START_MIN), 3'(START_TENS), 4'(START_ONES)};
    localparam logic [3:0]        INC_SEC_V  = 4'(INC_SEC);

    state_t            state_r, state_nx_s;
    logic [PRE_W-1:0]  pre_r, pre_nx_s;
    logic [TIME_W-1:0] cw_r, cw_nx_s, cb_r, cb_nx_s;
    logic              flag_w_r, flag_w_nx_s, flag_b_r, flag_b_nx_s;
    logic              active_w_r, active_b_r;
    logic              tick_s;
    logic              dec_w_s, dec_b_s, inc_w_s, inc_b_s;
    logic [TIME_W-1:0] step_w_s, step_b_s;
    logic              zero_w_s, zero_b_s;

    assign tick_s  = ((state_r == ST_RUN_W) || (state_r == ST_RUN_B)) && (pre_r == PRE_LAST);
    assign dec_w_s = (state_r == ST_RUN_W) && tick_s;
    assign dec_b_s = (state_r == ST_RUN_B) && tick_s;
`ifdef INCREMENT_EN
    assign inc_w_s = (state_r == ST_RUN_W) && move_w;
    assign inc_b_s = (state_r == ST_RUN_B) && move_b;
`else
    assign inc_w_s = 1'b0;
    assign inc_b_s = 1'b0;
`endif

    bcd_time_step step_w (
        .word      (cw_r),
        .dec_en    (dec_w_s),
        .inc_en    (inc_w_s),
        .inc_sec   (INC_SEC_V),
        .next_word (step_w_s),
        .is_zero   (zero_w_s)
    );

    bcd_time_step step_b (
        .word      (cb_r),
        .dec_en    (dec_b_s),
        .inc_en    (inc_b_s),
        .inc_sec   (INC_SEC_V),
        .next_word (step_b_s),
        .is_zero   (zero_b_s)
    );

    // Next-state, prescaler and countdown update; priority start > flag > move > pause
    always_comb begin
        state_nx_s  = state_r;
        pre_nx_s    = pre_r;
        cw_nx_s     = cw_r;
        cb_nx_s     = cb_r;
        flag_w_nx_s = flag_w_r;
        flag_b_nx_s = flag_b_r;
        if (start) begin
            state_nx_s  = ST_RUN_W;
            pre_nx_s    = '0;
            cw_nx_s     = START_TIME;
            cb_nx_s     = START_TIME;
            flag_w_nx_s = 1'b0;
            flag_b_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN_W: begin
                    pre_nx_s = tick_s ? '0 : pre_r + PRE_W'(1);
                    cw_nx_s  = step_w_s;
                    if (tick_s && zero_w_s) begin
                        flag_w_nx_s = 1'b1;
                        state_nx_s  = ST_FLAG;
                    end else if (move_w) begin
                        state_nx_s = ST_RUN_B;
                        pre_nx_s   = '0;
                    end else if (pause) begin
                        state_nx_s = ST_PAUSE_W;
                    end else begin
                        state_nx_s = ST_RUN_W;
                    end
                end
                ST_RUN_B: begin
                    pre_nx_s = tick_s ? '0 : pre_r + PRE_W'(1);
                    cb_nx_s  = step_b_s;
                    if (tick_s && zero_b_s) begin
                        flag_b_nx_s = 1'b1;
                        state_nx_s  = ST_FLAG;
                    end else if (move_b) begin
                        state_nx_s = ST_RUN_W;
                        pre_nx_s   = '0;
                    end else if (pause) begin
                        state_nx_s = ST_PAUSE_B;
                    end else begin
                        state_nx_s = ST_RUN_B;
                    end
                end
                ST_PAUSE_W: state_nx_s = pause ? ST_RUN_W : ST_PAUSE_W;
                ST_PAUSE_B: state_nx_s = pause ? ST_RUN_B : ST_PAUSE_B;
                ST_IDLE:    state_nx_s = ST_IDLE;
                ST_FLAG:    state_nx_s = ST_FLAG;
                default:    state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State and output registers; active flags are decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pre_r      <= '0;
            cw_r       <= START_TIME;
            cb_r       <= START_TIME;
            flag_w_r   <= 1'b0;
            flag_b_r   <= 1'b0;
            active_w_r <= 1'b0;
            active_b_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            pre_r      <= pre_nx_s;
            cw_r       <= cw_nx_s;
            cb_r       <= cb_nx_s;
            flag_w_r   <= flag_w_nx_s;
            flag_b_r   <= flag_b_nx_s;
            active_w_r <= (state_nx_s == ST_RUN_W);
            active_b_r <= (state_nx_s == ST_RUN_B);
        end
    end

    assign countdown_w = cw_r;
    assign countdown_b = cb_r;
    assign active_w    = active_w_r;
    assign active_b    = active_b_r;
    assign flag_w      = flag_w_r;
    assign flag_b      = flag_b_r;

endmodule

// File: tb/tb_chess_clock_countdown.sv
// Bench for chess_clock_countdown: seconds-based reference model checked every cycle,
// plus hand-computed literal checks. INCREMENT_EN-specific checks follow the same macro.
module tb_chess_clock_countdown;

    localparam int TICK    = 4;
    localparam int INC     = 2;
    localparam int START_S = 12;

`ifdef INCREMENT_EN
    localparam logic [9:0] EXP_W_AFTER_MB     = 10'b000_001_0010;
    localparam logic [9:0] EXP_W_AFTER_RESUME = 10'b000_001_0001;
    localparam logic [9:0] EXP_W_AFTER_TM     = 10'b000_001_0010;
`else
    localparam logic [9:0] EXP_W_AFTER_MB     = 10'b000_001_0000;
    localparam logic [9:0] EXP_W_AFTER_RESUME = 10'b000_000_1001;
    localparam logic [9:0] EXP_W_AFTER_TM     = 10'b000_000_1000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, move_w = 1'b0, move_b = 1'b0, pause = 1'b0;
    logic [9:0] countdown_w, countdown_b, cw2, cb2;
    logic       active_w, active_b, flag_w, flag_b;
    logic       aw2, ab2, fw2, fb2;
    int         total = 0;
    int         bad = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    chess_clock_countdown #(.TICK_CYCLES(TICK), .START_MIN(0), .START_TENS(1),
                            .START_ONES(2), .INC_SEC(INC)) dut (
        .clk(clk), .rst(rst), .start(start), .move_w(move_w), .move_b(move_b),
        .pause(pause), .countdown_w(countdown_w), .countdown_b(countdown_b),
        .active_w(active_w), .active_b(active_b), .flag_w(flag_w), .flag_b(flag_b));

    chess_clock_countdown #(.TICK_CYCLES(TICK), .START_MIN(1), .START_TENS(0),
                            .START_ONES(0), .INC_SEC(INC)) dut2 (
        .clk(clk), .rst(rst), .start(start), .move_w(move_w), .move_b(move_b),
        .pause(pause), .countdown_w(cw2), .countdown_b(cb2),
        .active_w(aw2), .active_b(ab2), .flag_w(fw2), .flag_b(fb2));

`ifdef INCREMENT_EN
    logic [9:0] cw3, cb3, cw4, cb4;
    logic       aw3, ab3, fw3, fb3, aw4, ab4, fw4, fb4;

    chess_clock_countdown #(.TICK_CYCLES(TICK), .START_MIN(0), .START_TENS(5),
                            .START_ONES(9), .INC_SEC(INC)) dut3 (
        .clk(clk), .rst(rst), .start(start), .move_w(move_w), .move_b(move_b),
        .pause(pause), .countdown_w(cw3), .countdown_b(cb3),
        .active_w(aw3), .active_b(ab3), .flag_w(fw3), .flag_b(fb3));

    chess_clock_countdown #(.TICK_CYCLES(TICK), .START_MIN(5), .START_TENS(5),
                            .START_ONES(9), .INC_SEC(INC)) dut4 (
        .clk(clk), .rst(rst), .start(start), .move_w(move_w), .move_b(move_b),
        .pause(pause), .countdown_w(cw4), .countdown_b(cb4),
        .active_w(aw4), .active_b(ab4), .flag_w(fw4), .flag_b(fb4));
`endif

    // Reference model: times in plain seconds, mode 0 idle / 1 running / 2 paused / 3 flagged
    int m_t[2];
    bit m_flag[2];
    int m_mode;
    int m_turn;
    int m_pre;
    bit m_tick;

    function automatic logic [9:0] pack(input int s);
        return {3'(s / 60), 3'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t[0] = START_S; m_t[1] = START_S;
            m_flag[0] = 1'b0; m_flag[1] = 1'b0;
            m_mode = 0; m_turn = 0; m_pre = 0;
        end else if (start) begin
            m_t[0] = START_S; m_t[1] = START_S;
            m_flag[0] = 1'b0; m_flag[1] = 1'b0;
            m_mode = 1; m_turn = 0; m_pre = 0;
        end else if (m_mode == 1) begin
            m_tick = (m_pre == TICK - 1);
            m_pre  = m_tick ? 0 : m_pre + 1;
            if (m_tick && m_t[m_turn] > 0) m_t[m_turn] = m_t[m_turn] - 1;
            if (m_tick && m_t[m_turn] == 0) begin
                m_flag[m_turn] = 1'b1;
                m_mode = 3;
            end else if ((m_turn == 0 && move_w) || (m_turn == 1 && move_b)) begin
`ifdef INCREMENT_EN
                m_t[m_turn] = (m_t[m_turn] + INC > 359) ? 359 : m_t[m_turn] + INC;
`endif
                m_turn = 1 - m_turn;
                m_pre  = 0;
            end else if (pause) begin
                m_mode = 2;
            end
        end else if (m_mode == 2) begin
            if (pause) m_mode = 1;
        end
    end

    // Single compare process: every output against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_cw", countdown_w, pack(m_t[0]));
            chk("model_cb", countdown_b, pack(m_t[1]));
            chk("model_aw", {9'd0, active_w}, {9'd0, (m_mode == 1 && m_turn == 0)});
            chk("model_ab", {9'd0, active_b}, {9'd0, (m_mode == 1 && m_turn == 1)});
            chk("model_fw", {9'd0, flag_w}, {9'd0, m_flag[0]});
            chk("model_fb", {9'd0, flag_b}, {9'd0, m_flag[1]});
        end
    end

    task automatic pulse(input logic [3:0] m);
        {start, move_w, move_b, pause} = m;
        @(negedge clk);
        {start, move_w, move_b, pause} = 4'b0000;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_cw", countdown_w, 10'b000_001_0010);
        chk("rst_aw", {9'd0, active_w}, 10'd0);

        // Full countdown of White to 0:00
        pulse(4'b1000);
        wait_cyc(4);
        chk("tick1_cw", countdown_w, 10'b000_001_0001);
        chk("start100_cw", cw2, 10'b000_101_1001);
        wait_cyc(8);
        chk("borrow_cw", countdown_w, 10'b000_000_1001);
        wait_cyc(36);
        chk("zero_cw", countdown_w, 10'b000_000_0000);
        chk("zero_fw", {9'd0, flag_w}, 10'd1);
        chk("zero_aw", {9'd0, active_w}, 10'd0);
        chk("zero_cb", countdown_b, 10'b000_001_0010);
        pulse(4'b0100);
        pulse(4'b0001);
        wait_cyc(3);
        chk("frozen_cw", countdown_w, 10'b000_000_0000);

        // Asynchronous reset in the middle of a run
        pulse(4'b1000);
        wait_cyc(6);
        #2 rst = 1'b1;
        #1;
        chk("arst_cw", countdown_w, 10'b000_001_0010);
        chk("arst_aw", {9'd0, active_w}, 10'd0);
        chk("arst_fw", {9'd0, flag_w}, 10'd0);
        @(negedge clk);
        rst = 1'b0;

        // Turn switching and prescaler clear
        pulse(4'b1000);
        wait_cyc(9);
        pulse(4'b0100);
        chk("switch_ab", {9'd0, active_b}, 10'd1);
        pulse(4'b0100);
        wait_cyc(2);
        chk("presc_clr_cb", countdown_b, 10'b000_001_0010);
        wait_cyc(1);
        chk("black_tick_cb", countdown_b, 10'b000_001_0001);
        pulse(4'b0010);
        chk("back_w_cw", countdown_w, EXP_W_AFTER_MB);
        chk("back_w_aw", {9'd0, active_w}, 10'd1);

        // Pause holds time and prescaler
        wait_cyc(2);
        pulse(4'b0001);
        wait_cyc(20);
        chk("paused_cw", countdown_w, EXP_W_AFTER_MB);
        pulse(4'b0001);
        wait_cyc(1);
        chk("resume_cw", countdown_w, EXP_W_AFTER_RESUME);

        // Tick and move on the same edge, then both moves together
        wait_cyc(3);
        pulse(4'b0100);
        chk("tickmove_cw", countdown_w, EXP_W_AFTER_TM);
        chk("tickmove_ab", {9'd0, active_b}, 10'd1);
        pulse(4'b0110);
        chk("both_aw", {9'd0, active_w}, 10'd1);
        wait_cyc(5);

`ifdef INCREMENT_EN
        pulse(4'b1000);
        wait_cyc(5);
        pulse(4'b0100);
        chk("inc_carry_cw", cw3, 10'b001_000_0000);
        chk("inc_sat_cw", cw4, 10'b101_101_1001);
        wait_cyc(3);
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chess_clock_countdown.md
Name: chess_clock_countdown

Overview:
- Two-player chess-clock timekeeper. Produces the packed countdown words that the board-display digit decoder consumes.
- Word format: [9:7] minutes (0-5), [6:4] seconds tens (0-5), [3:0] seconds ones (0-9). Maximum value 5:59.
- Counts down the active player's time once per second. Switches turns on move buttons. Raises a flag when a player reaches 0:00.

Parameters:
- TICK_CYCLES, 100000000, clk cycles per one-second tick (a bench sets it small).
- START_MIN, 5, reload value for the minutes field (0-5).
- START_TENS, 0, reload value for the seconds-tens field (0-5).
- START_ONES, 0, reload value for the seconds-ones field (0-9).
- INC_SEC, 2, per-move increment in seconds (0-9). Used only when INCREMENT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: reload both clocks and begin White's turn.
- move_w  in  1  single-cycle pulse: White has completed a move.
- move_b  in  1  single-cycle pulse: Black has completed a move.
- pause  in  1  single-cycle pulse: toggle between running and paused.
- countdown_w  out  10  White's remaining time, packed format.
- countdown_b  out  10  Black's remaining time, packed format.
- active_w  out  1  White's clock is running.
- active_b  out  1  Black's clock is running.
- flag_w  out  1  White ran out of time (sticky).
- flag_b  out  1  Black ran out of time (sticky).

Behaviour:
- Reset values:
  - countdown_w = countdown_b = {START_MIN, START_TENS, START_ONES}.
  - All status outputs = 0.
  - Prescaler = 0. State = IDLE.
- All outputs are registered.
- States: IDLE, RUN_W, RUN_B, PAUSE_W, PAUSE_B, FLAG.
- start, from any state: reload both words, clear both flags, clear prescaler, go to RUN_W on the next edge.
- Prescaler:
  - Counts only in RUN_W and RUN_B.
  - Asserts tick when it equals TICK_CYCLES-1, then wraps to 0.
  - Cleared on every turn switch and on start.
  - Holds its value through pause.
- Tick in RUN_W decrements countdown_w by one second, with BCD borrow:
  - ones>0: ones-1.
  - ones=0 and tens>0: ones=9, tens-1.
  - ones=0 and tens=0: ones=9, tens=5, min-1.
  - RUN_B does the same on countdown_b.
- Reaching 0:00:
  - When a decrement produces 0:00, that player's flag sets on the same edge. State goes to FLAG and both active outputs drop.
  - The word holds 0:00 and is never decremented below it.
- FLAG: everything frozen. Only start or rst leave it.
- Turn switching:
  - move_w in RUN_W goes to RUN_B.
  - move_b in RUN_B goes to RUN_W.
  - A move pulse from the non-active player is ignored.
  - Moves are ignored in IDLE, PAUSE_x and FLAG.
- move_w and move_b in the same cycle: only the active player's pulse is honoured.
- Tick and a valid move in the same cycle: the decrement is applied to the mover first, then the turn switches.
  - If that decrement reaches 0:00, FLAG wins and no switch happens.
- Pause:
  - pause in RUN_x goes to PAUSE_x. pause in PAUSE_x returns to RUN_x.
  - pause is ignored in IDLE and FLAG.
  - start takes priority over pause and move.
- active_w=1 only in RUN_W. active_b=1 only in RUN_B.
- Out-of-range field values (min>5, tens>5, ones>9) are never generated.

Optional Feature:
- Macro: INCREMENT_EN.
- Defined: on a valid turn switch, INC_SEC seconds are BCD-added to the mover's word. This happens after any same-cycle tick decrement.
  - Carry rules: ones>9 carries into tens; tens>5 carries into min.
  - Result saturates at 5:59.
  - Not applied if the mover flagged that cycle.
- Not defined: no increment logic. INC_SEC is unused.

Decomposition:
- Package chess_clock_pkg:
  - Field widths: MIN_W=3, TENS_W=3, ONES_W=4.
  - Constants: MAX_TIME (5:59), ZERO_TIME.
  - State enum.
- Sub-module bcd_time_step, purely combinational, one instance per player:
  - Inputs: packed word, dec_en, inc_en, inc_sec.
  - Outputs: next word, is_zero.
- The top level owns the FSM and prescaler.

Test Plan (all with TICK_CYCLES=4, START=0:12):
- rst asserted mid-run, asynchronously → countdown_w=countdown_b=10'b000_001_0010 immediately, state IDLE, all flags and active outputs 0.
- start, then 12 ticks (48 cycles) → countdown_w steps 0:11 … 0:10, 0:09 (borrow: ones 0→9, tens 1→0), … down to 0:00. flag_w=1 on the edge that produces 0:00, active_w=0, countdown_b stays 0:12.
- START=1:00, one tick → countdown_w=0:59 (10'b000_101_1001).
- move_w after 2 ticks → active_b=1, prescaler cleared. move_w repeated → ignored. move_b → back to White with countdown_w=0:10.
- pause for 20 cycles, then pause again → no decrement while paused. The prescaler resumes from its held value.
- With INCREMENT_EN, INC_SEC=2: White at 0:58 presses move_w → countdown_w=1:00 (carry). White at 5:58 presses move_w → countdown_w saturates at 5:59.
